// File: rtl/seq_addsub_pkg.sv
// ---------------------------------------------------------------------------
// seq_addsub_pkg
// Shared definitions for the chunk-serial adder/subtractor:
//   state_e - controller states (IDLE accepts, RUN adds, DONE presents)
//   nchunk  - number of CHUNK-bit slices making up a WIDTH-bit operand
// ---------------------------------------------------------------------------
package seq_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

endpackage

// File: rtl/seq_addsub_chunk.sv
// ---------------------------------------------------------------------------
// addsub_chunk
// Combinational CHUNK-bit ripple-carry adder built from full-adder cells.
// Ports:
//   a_i, b_i  [CHUNK-1:0] : addends (b_i is already inverted for subtract)
//   c_i                   : carry into bit 0
//   s_o       [CHUNK-1:0] : sum slice
//   c_o                   : carry out of bit CHUNK-1
//   c_top_o               : carry into bit CHUNK-1 (used for overflow)
// ---------------------------------------------------------------------------
module addsub_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             c_i,
  output logic [CHUNK-1:0] s_o,
  output logic             c_o,
  output logic             c_top_o
);

  // carry[i] is the carry into bit i
  logic [CHUNK:0] carry;

  assign carry[0] = c_i;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    assign s_o[i]       = a_i[i] ^ b_i[i] ^ carry[i];
    assign carry[i + 1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
  end

  assign c_o     = carry[CHUNK];
  assign c_top_o = carry[CHUNK-1];

endmodule

// File: rtl/seq_addsub.sv
// ---------------------------------------------------------------------------
// seq_addsub
// Chunk-serial two's-complement adder/subtractor. One operand set is accepted
// in IDLE, CHUNK bits are added per clock LSB-first in RUN, and the result is
// held in DONE until the consumer takes it.
// Optional feature macro: SEQ_ADDSUB_OVF_EN (enables overflow tracking; when
// undefined, ovf is tied to 0).
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   in_valid/ready  : operand handshake (a, b, cin, sub)
//   out_valid/ready : result handshake (sum, cout, ovf)
// ---------------------------------------------------------------------------
module seq_addsub
  import seq_addsub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  if ((CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_cfg_err
    $error("seq_addsub: WIDTH must be a positive multiple of CHUNK");
  end

  state_e           state_q;
  logic [KW-1:0]    k_q;
  logic             carry_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;     // b already transformed for the selected mode
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;

  int               base;
  logic             last;
  logic [CHUNK-1:0] chunk_a;
  logic [CHUNK-1:0] chunk_b;
  logic [CHUNK-1:0] chunk_sum;
  logic             chunk_c;

  assign base    = int'(k_q) * CHUNK;
  assign last    = (k_q == KW'(NCHUNK - 1));
  assign chunk_a = a_q[base +: CHUNK];
  assign chunk_b = b_q[base +: CHUNK];

`ifdef SEQ_ADDSUB_OVF_EN
  logic chunk_ctop;

  addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a_i     (chunk_a),
    .b_i     (chunk_b),
    .c_i     (carry_q),
    .s_o     (chunk_sum),
    .c_o     (chunk_c),
    .c_top_o (chunk_ctop)
  );
`else
  logic chunk_ctop_unused;

  addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a_i     (chunk_a),
    .b_i     (chunk_b),
    .c_i     (carry_q),
    .s_o     (chunk_sum),
    .c_o     (chunk_c),
    .c_top_o (chunk_ctop_unused)
  );
`endif

  // Controller and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            // Subtract as a + ~b + 1; cin only matters when adding
            b_q     <= sub ? ~b : b;
            carry_q <= sub ? 1'b1 : cin;
            k_q     <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          sum_q[base +: CHUNK] <= chunk_sum;
          carry_q              <= chunk_c;
          if (last) begin
            cout_q  <= chunk_c;
            k_q     <= '0;
            state_q <= DONE;
          end else begin
            k_q <= k_q + KW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef SEQ_ADDSUB_OVF_EN
  logic ovf_q;

  // Overflow captured together with the final chunk's carry
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if ((state_q == RUN) && last) begin
      ovf_q <= chunk_ctop ^ chunk_c;
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: doc/seq_addsub.md
SEQ_ADDSUB -- requirements
Module: seq_addsub

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand/result width in bits.
REQ-002 SHALL have parameter CHUNK, default 4: bits added per clock; WIDTH % CHUNK == 0 required, else elaboration error.
REQ-003 SHALL have port clk, input, 1: single clock, all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1: operand set offered.
REQ-006 SHALL have port in_ready, output, 1: block can accept operands.
REQ-007 SHALL have ports a and b, input, WIDTH each: operands.
REQ-008 SHALL have port cin, input, 1: carry-in for add mode.
REQ-009 SHALL have port sub, input, 1: 0 = add, 1 = subtract.
REQ-010 SHALL have port out_valid, output, 1: result available.
REQ-011 SHALL have port out_ready, input, 1: consumer accepts result.
REQ-012 SHALL have port sum, output, WIDTH: result.
REQ-013 SHALL have port cout, output, 1: carry out of MSB.
REQ-014 SHALL have port ovf, output, 1: two's-complement overflow.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, DONE; in_ready = (state==IDLE), out_valid = (state==DONE).
REQ-016 IDLE: on in_valid&&in_ready SHALL latch a, b, cin, sub, clear chunk index, go to RUN.
REQ-017 Operand transform SHALL be: b_eff = sub ? ~b : b; c_in_eff = sub ? 1 : cin; in sub mode cin is ignored.
REQ-018 RUN: each cycle SHALL add chunk k of a and b_eff with stored carry (c_in_eff for k=0), write sum slice [k*CHUNK +: CHUNK], store carry, k increments LSB-first.
REQ-019 After chunk NCHUNK-1 (NCHUNK = WIDTH/CHUNK) SHALL go to DONE; out_valid SHALL rise exactly NCHUNK cycles after the accepting edge.
REQ-020 cout SHALL be the carry out of bit WIDTH-1; ovf SHALL be carry-into-MSB XOR carry-out-of-MSB.
REQ-021 DONE: sum, cout, ovf SHALL be stable while out_valid is high; on out_valid&&out_ready SHALL return to IDLE next cycle.
REQ-022 in_ready SHALL be 0 in RUN and DONE; in_valid in those states SHALL be ignored, with no queuing.
REQ-023 in_valid SHALL be sampled only in IDLE; a, b, cin and sub may change freely after acceptance without affecting the result.
REQ-024 CHUNK==WIDTH SHALL be legal: one RUN cycle, latency 1.
REQ-025 Back-to-back: next accept SHALL be possible the cycle after the output handshake; minimum period is NCHUNK+2 cycles.

Reset
REQ-026 rst SHALL force state=IDLE, chunk index=0, stored carry=0, sum=0, cout=0, ovf=0 on the next edge; rst has priority over all other inputs.
REQ-027 Reset during RUN or DONE SHALL abort the operation, with no out_valid for it; in_ready=1 on the cycle after reset.

Configuration
REQ-028 Macro SEQ_ADDSUB_OVF_EN defined: ovf SHALL be computed per REQ-020 and registered with the sum.
REQ-029 Macro SEQ_ADDSUB_OVF_EN undefined: ovf port SHALL remain and be driven constant 0, with no MSB carry-in tracking logic.

Structure
REQ-030 Package seq_addsub_pkg SHALL hold the state typedef (IDLE/RUN/DONE) and a function computing NCHUNK from WIDTH and CHUNK.
REQ-031 SHALL instantiate one sub-module addsub_chunk: combinational CHUNK-bit ripple adder built from full-adder cells, exposing sum, carry-out and carry into its top bit.

Verification (WIDTH=16, CHUNK=4 unless stated)
REQ-032 Test 1: a=0xFFFF, b=0x0001, sub=0, cin=0 -> sum=0x0000, cout=1, ovf=0, out_valid 4 cycles after accept.
REQ-033 Test 2: a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, cout=1, ovf=1 (OVF_EN defined), ovf=0 (undefined).
REQ-034 Test 3: a=0x7FFF, b=0x0000, sub=0, cin=1 -> sum=0x8000, cout=0, ovf=1.
REQ-035 Test 4: out_ready held low 10 cycles in DONE -> sum, cout, ovf and out_valid unchanged, in_ready=0; release -> IDLE next cycle.
REQ-036 Test 5: rst pulsed at chunk index 2 -> IDLE next cycle, no out_valid, all outputs 0, in_ready=1.
REQ-037 Test 6: WIDTH=CHUNK=16, a=0x1234, b=0x1111, sub=1 -> sum=0x0123, cout=1, out_valid 1 cycle after accept.
